// File: rtl/pixel_scheduler_if.sv
// Engine dispatch, engine completion and retired-pixel stream of the pixel scheduler.
// The scheduler takes the master side; engines and packer take the slave side.
interface pixel_scheduler_if #(
    parameter int NUM_ENGINES = 4
);
    logic                     enable;
    logic [NUM_ENGINES-1:0]   eng_start;
    logic [15:0]              eng_x;
    logic [15:0]              eng_y;
    logic [NUM_ENGINES-1:0]   eng_done;
    logic [8*NUM_ENGINES-1:0] eng_iter;
    logic [7:0]               pix_iter;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     pix_sof;
    logic                     pix_eol;
    logic                     frame_done;
    logic                     busy;

    modport master (
        input  enable, eng_done, eng_iter, pix_ready,
        output eng_start, eng_x, eng_y, pix_iter, pix_valid, pix_sof, pix_eol,
               frame_done, busy
    );

    modport slave (
        output enable, eng_done, eng_iter, pix_ready,
        input  eng_start, eng_x, eng_y, pix_iter, pix_valid, pix_sof, pix_eol,
               frame_done, busy
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Hands raster-order pixels to a ring of iteration engines and retires their results
// in raster order, whatever order the engines finish in.
//
// frame state | meaning
// ST_DISPATCH | frame still has undispatched pixels
// ST_DRAIN    | last pixel dispatched; waiting for it to be accepted
//
// slot state   | meaning
// SLOT_FREE    | engine idle, may be started
// SLOT_PENDING | engine started, awaiting eng_done
// SLOT_HELD    | result buffered, awaiting retire
module pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 1280,
    parameter int Y_SIZE      = 960
) (
    input  logic               aclk,
    input  logic               areset,
    pixel_scheduler_if.master  bus
);
    localparam int PW = $clog2(NUM_ENGINES);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_PENDING, SLOT_HELD} slot_t;
    typedef enum logic {ST_DISPATCH, ST_DRAIN} state_t;

    state_t        state, state_next;
    slot_t         slot_q [NUM_ENGINES];
    slot_t         slot_d [NUM_ENGINES];
    logic [7:0]    buf_q  [NUM_ENGINES];
    logic [PW-1:0] dptr, rptr;
    logic [15:0]   dx, dy, rx, ry;
    logic          dispatch, retire, d_last, r_last, busy_c;

    assign d_last = (dx == 16'(X_SIZE-1)) && (dy == 16'(Y_SIZE-1));
    assign r_last = (rx == 16'(X_SIZE-1)) && (ry == 16'(Y_SIZE-1));

    assign bus.pix_valid = (slot_q[rptr] == SLOT_HELD);
    assign bus.pix_iter  = buf_q[rptr];
    assign bus.pix_sof   = (rx == 16'd0) && (ry == 16'd0);
    assign bus.pix_eol   = (rx == 16'(X_SIZE-1));
    assign bus.busy      = busy_c;
    assign retire        = bus.pix_valid && bus.pix_ready;

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < NUM_ENGINES; k++)
            if (slot_q[k] != SLOT_FREE) busy_c = 1'b1;
    end

    always_comb begin
        state_next = state;
        dispatch   = 1'b0;
        case (state)
            ST_DISPATCH: begin
                dispatch = bus.enable && (slot_q[dptr] == SLOT_FREE);
                if (dispatch && d_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (retire && r_last) state_next = ST_DISPATCH;
            end
            default: state_next = ST_DISPATCH;
        endcase
    end

    // Per slot the three events are mutually exclusive, since each needs a different current state.
    always_comb begin
        for (int k = 0; k < NUM_ENGINES; k++) begin
            slot_d[k] = slot_q[k];
            if (dispatch && dptr == PW'(k))
                slot_d[k] = SLOT_PENDING;
            if (bus.eng_done[k] && slot_q[k] == SLOT_PENDING)
                slot_d[k] = SLOT_HELD;
            if (retire && rptr == PW'(k))
                slot_d[k] = SLOT_FREE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= ST_DISPATCH;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_q[k] <= SLOT_FREE;
                buf_q[k]  <= '0;
            end
            dptr           <= '0;
            rptr           <= '0;
            dx             <= '0;
            dy             <= '0;
            rx             <= '0;
            ry             <= '0;
            bus.eng_start  <= '0;
            bus.eng_x      <= '0;
            bus.eng_y      <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_next;
            slot_q         <= slot_d;
            for (int k = 0; k < NUM_ENGINES; k++)
                if (bus.eng_done[k] && slot_q[k] == SLOT_PENDING)
                    buf_q[k] <= bus.eng_iter[8*k +: 8];
            bus.eng_start  <= '0;
            bus.frame_done <= retire && r_last;
            if (dispatch) begin
                bus.eng_start <= NUM_ENGINES'(1) << dptr;
                bus.eng_x     <= dx;
                bus.eng_y     <= dy;
                dptr          <= dptr + 1'b1;
                // The last coordinate is held until its pixel retires, then both sides wrap together.
                if (!d_last) begin
                    if (dx == 16'(X_SIZE-1)) begin
                        dx <= '0;
                        dy <= dy + 16'd1;
                    end else begin
                        dx <= dx + 16'd1;
                    end
                end
            end
            if (retire) begin
                if (r_last) begin
                    rx   <= '0;
                    ry   <= '0;
                    dx   <= '0;
                    dy   <= '0;
                    rptr <= '0;
                    dptr <= '0;
                end else begin
                    rptr <= rptr + 1'b1;
                    if (rx == 16'(X_SIZE-1)) begin
                        rx <= '0;
                        ry <= ry + 16'd1;
                    end else begin
                        rx <= rx + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// Self-checking bench for pixel_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the dispatched-but-unretired pixels.
module tb_pixel_scheduler;
    localparam int N    = 4;
    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int NPIX = XS * YS;

    logic aclk = 1'b0;
    logic areset;

    pixel_scheduler_if #(.NUM_ENGINES(N)) bus ();

    pixel_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    // st: 0 engine running, 1 done driven toward next edge, 2 result captured by the DUT
    typedef struct { int eng; int x; int y; int iter; int st; } pix_t;

    pix_t q[$];
    int   ret_log[$];
    int   start_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   disp_cnt = 0;
    int   last_x = 0;
    int   last_y = 0;
    int   fd_count = 0;
    int   ready_pct = 100;
    bit   exp_disp = 1'b0;
    bit   exp_fd = 1'b0;
    bit   rst_pending = 1'b1;
    bit   en = 1'b0;
    bit   do_rst = 1'b0;
    int   eng_cd [N];
    int   eng_it [N];
    int   force_lat [N];
    int   force_iter [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit eng_busy(input int e);
        foreach (q[i]) if (q[i].eng == e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_force();
        for (int k = 0; k < N; k++) begin
            force_lat[k]  = -1;
            force_iter[k] = -1;
        end
    endtask

    // One clock: observe the DUT after the edge, update the model, drive inputs for the next edge.
    task automatic cycle();
        bit   valid;
        bit   accept;
        int   e;
        pix_t p;
        @(posedge aclk);
        #1;
        if (bus.frame_done === 1'b1) fd_count++;
        valid = 1'b0;
        if (rst_pending) begin
            q.delete();
            disp_cnt = 0;
            last_x   = 0;
            last_y   = 0;
            exp_fd   = 1'b0;
            chk("rst_start", 32'(bus.eng_start), 0);
            chk("rst_x", 32'(bus.eng_x), 0);
            chk("rst_y", 32'(bus.eng_y), 0);
            chk("rst_valid", 32'(bus.pix_valid), 0);
            chk("rst_iter", 32'(bus.pix_iter), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_fdone", 32'(bus.frame_done), 0);
        end else begin
            foreach (q[i]) if (q[i].st == 1) q[i].st = 2;
            chk("start_when", 32'(bus.eng_start != '0), 32'(exp_disp));
            if (bus.eng_start != '0) begin
                e = disp_cnt % N;
                chk("start_eng", 32'(bus.eng_start), 1 << e);
                chk("start_x", 32'(bus.eng_x), disp_cnt % XS);
                chk("start_y", 32'(bus.eng_y), disp_cnt / XS);
                p.eng  = e;
                p.x    = disp_cnt % XS;
                p.y    = disp_cnt / XS;
                p.iter = (force_iter[e] >= 0) ? force_iter[e] : int'($urandom_range(0, 255));
                p.st   = 0;
                q.push_back(p);
                eng_cd[e] = (force_lat[e] >= 0) ? force_lat[e] : int'($urandom_range(1, 6));
                eng_it[e] = p.iter;
                last_x    = p.x;
                last_y    = p.y;
                disp_cnt++;
                start_log.push_back(e);
            end else begin
                chk("x_hold", 32'(bus.eng_x), last_x);
                chk("y_hold", 32'(bus.eng_y), last_y);
            end
            chk("busy", 32'(bus.busy), 32'(q.size() != 0));
            chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
            valid = (q.size() != 0) && (q[0].st == 2);
            chk("pix_valid", 32'(bus.pix_valid), 32'(valid));
            if (valid) begin
                chk("pix_iter", 32'(bus.pix_iter), q[0].iter);
                chk("pix_sof", 32'(bus.pix_sof), 32'(q[0].x == 0 && q[0].y == 0));
                chk("pix_eol", 32'(bus.pix_eol), 32'(q[0].x == XS-1));
            end
        end

        rst_pending  = do_rst;
        bus.eng_done = '0;
        for (int k = 0; k < N; k++) begin
            bus.eng_iter[8*k +: 8] = 8'($urandom);
            if (eng_cd[k] > 0) begin
                eng_cd[k]--;
                if (eng_cd[k] == 0) begin
                    bus.eng_done[k]        = 1'b1;
                    bus.eng_iter[8*k +: 8] = 8'(eng_it[k]);
                    foreach (q[i]) if (q[i].eng == k && q[i].st == 0) q[i].st = 1;
                end
            end
        end
        bus.enable    = en;
        areset        = do_rst;
        bus.pix_ready = (int'($urandom_range(0, 99)) < ready_pct);
        exp_disp = !do_rst && en && (disp_cnt < NPIX) && !eng_busy(disp_cnt % N);
        accept   = !do_rst && valid && bus.pix_ready;
        exp_fd   = 1'b0;
        if (accept) begin
            ret_log.push_back(q[0].iter);
            if (q[0].x == XS-1 && q[0].y == YS-1) begin
                exp_fd   = 1'b1;
                disp_cnt = 0;
            end
            void'(q.pop_front());
        end
    endtask

    task automatic do_reset();
        do_rst = 1'b1;
        cycle();
        do_rst = 1'b0;
        cycle();
        ret_log.delete();
        start_log.delete();
        fd_count = 0;
    endtask

    task automatic wait_retired(input int n, input int budget, input string tag);
        int c = 0;
        while (ret_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, 32'(ret_log.size() >= n), 1);
    endtask

    task automatic wait_started(input int n, input int budget, input string tag);
        int c = 0;
        while (start_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, 32'(start_log.size() >= n), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int s1;
        areset        = 1'b1;
        bus.enable    = 1'b0;
        bus.eng_done  = '0;
        bus.eng_iter  = '0;
        bus.pix_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            eng_cd[k] = 0;
            eng_it[k] = 0;
        end
        clear_force();
        cycle();

        // In-order completion, iter = 10+k
        for (int k = 0; k < N; k++) begin
            force_iter[k] = 10 + k;
            force_lat[k]  = 2;
        end
        en = 1'b1;
        ready_pct = 100;
        do_reset();
        wait_retired(4, 40, "inorder_timeout");
        for (int k = 0; k < 4; k++) begin
            chk("inorder_eng", start_log[k], k);
            chk("inorder_iter", ret_log[k], 10 + k);
        end

        // Out-of-order completion: engine 2, then 0, then 1
        clear_force();
        force_iter[0] = 3; force_lat[0] = 6;
        force_iter[1] = 5; force_lat[1] = 7;
        force_iter[2] = 7; force_lat[2] = 2;
        force_lat[3]  = 8;
        do_reset();
        wait_retired(3, 40, "ooo_timeout");
        chk("ooo_iter0", ret_log[0], 3);
        chk("ooo_iter1", ret_log[1], 5);
        chk("ooo_iter2", ret_log[2], 7);

        // Backpressure with slot 0 held, then the full frame
        clear_force();
        force_iter[0] = 9; force_lat[0] = 1;
        ready_pct = 0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", 32'(bus.pix_valid), 1);
            chk("bp_iter", 32'(bus.pix_iter), 9);
            chk("bp_starts", start_log.size(), 4);
        end
        ready_pct = 100;
        wait_retired(8, 60, "frame_timeout");
        wait_started(9, 20, "next_frame_timeout");
        chk("frame_done_count", fd_count, 1);
        chk("next_frame_eng", start_log[8], 0);

        // Reset after 3 dispatches, stale done, enable pause and resume
        clear_force();
        for (int k = 0; k < N; k++) force_lat[k] = 20;
        en = 1'b1;
        do_reset();
        cycle();
        cycle();
        do_rst = 1'b1;
        en = 1'b0;
        cycle();
        do_rst = 1'b0;
        cycle();
        chk("pre_reset_starts", start_log.size(), 3);
        for (int i = 0; i < 25; i++) cycle();
        chk("stale_valid", 32'(bus.pix_valid), 0);
        chk("stale_busy", 32'(bus.busy), 0);
        clear_force();
        ready_pct = 70;
        en = 1'b1;
        s0 = start_log.size();
        wait_started(s0 + 5, 40, "resume_timeout");
        en = 1'b0;
        cycle();
        s1 = start_log.size();
        for (int i = 0; i < 40; i++) cycle();
        chk("paused_starts", start_log.size(), s1);
        chk("paused_drained", q.size(), 0);
        chk("paused_busy", 32'(bus.busy), 0);
        en = 1'b1;
        cycle();
        cycle();
        chk("resumed", 32'(start_log.size() > s1), 1);

        // Randomized traffic with occasional resets
        ready_pct = 70;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = (i % 600 == 0) ? 30 : ((i % 400 == 0) ? 100 : 70);
            en     = ($urandom_range(0, 9) != 0);
            do_rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        do_rst = 1'b0;
        en = 1'b0;
        ready_pct = 100;
        cycle();
        for (int i = 0; i < 100 && q.size() != 0; i++) cycle();
        chk("rand_drained", q.size(), 0);
        chk("rand_frames", 32'(fd_count > 0), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, default 4: number of fractal iteration engines served; power of two, 2..8.
REQ-002 Parameter X_SIZE, default 1280: pixels per line.
REQ-003 Parameter Y_SIZE, default 960: lines per frame.
REQ-004 aclk  input  1  the block's single clock; all logic SHALL be on its rising edge.
REQ-005 areset  input  1  reset, synchronous and active-high.
REQ-006 enable  input  1  run control; high permits dispatch of new pixels.
REQ-007 eng_start  output  NUM_ENGINES  one-hot, single-cycle start pulse to engine k.
REQ-008 eng_x  output  16  pixel x for the engine being started; valid while eng_start is nonzero.
REQ-009 eng_y  output  16  pixel y for the engine being started; valid while eng_start is nonzero.
REQ-010 eng_done  input  NUM_ENGINES  single-cycle completion pulse from engine k.
REQ-011 eng_iter  input  8*NUM_ENGINES  iteration count of engine k in bits [8k+7:8k]; valid with eng_done[k].
REQ-012 pix_iter  output  8  iteration count of the retired pixel, in raster order.
REQ-013 pix_valid  output  1  pix_iter and the flags are valid.
REQ-014 pix_ready  input  1  downstream (packer) accepts the pixel when pix_valid && pix_ready.
REQ-015 pix_sof  output  1  the retired pixel is (0,0).
REQ-016 pix_eol  output  1  the retired pixel has x == X_SIZE-1.
REQ-017 frame_done  output  1  single-cycle pulse after the last pixel of a frame is accepted.
REQ-018 busy  output  1  high while any slot is pending or holding a result.

Function
REQ-019 Each engine slot k SHALL be in one state: FREE, PENDING (started, awaiting done) or HELD (result stored, awaiting retire).
REQ-020 Dispatch pointer dptr SHALL start at 0 and increment modulo NUM_ENGINES after each dispatch.
REQ-021 Dispatch condition: enable high, slot dptr FREE, and the frame not fully dispatched.
- When met at an edge, eng_start[dptr] and eng_x/eng_y SHALL be registered for exactly the next cycle.
- Slot dptr SHALL become PENDING.
- Dispatch coordinates SHALL advance in raster order.
REQ-022 Dispatch rate: at most one dispatch per cycle. eng_x/eng_y SHALL hold their last value when no start is issued.
REQ-023 eng_done[k] with slot k PENDING: eng_iter[k] SHALL be captured into buffer k at that edge and slot k SHALL become HELD. eng_done for a slot that is not PENDING SHALL be ignored.
REQ-024 Multiple eng_done bits in the same cycle SHALL all be captured.
REQ-025 Retire pointer rptr SHALL start at 0. pix_valid SHALL equal (slot rptr HELD), as a registered state.
- pix_iter SHALL equal buffer[rptr].
- First pix_valid SHALL occur the cycle after the capturing edge.
REQ-026 On pix_valid && pix_ready: slot rptr SHALL become FREE, rptr SHALL increment modulo NUM_ENGINES, and the retire coordinates SHALL advance in raster order.
REQ-027 A slot freed by retire SHALL be dispatchable no earlier than the following cycle.
REQ-028 pix_valid, pix_iter, pix_sof and pix_eol SHALL remain stable while pix_valid && !pix_ready.
REQ-029 pix_sof and pix_eol SHALL be derived from the retire coordinates, not the dispatch coordinates.
REQ-030 After dispatch of (X_SIZE-1, Y_SIZE-1), dispatch SHALL stall until that pixel is accepted.
- On acceptance, frame_done SHALL pulse for the next cycle and dispatch and retire coordinates SHALL wrap to (0,0).
- The next frame SHALL start if enable is high.
REQ-031 enable low SHALL stop new dispatches only. In-flight pixels SHALL still complete and retire. On re-enable, dispatch SHALL resume at the next undispatched coordinate.
REQ-032 Pixel order at pix_* SHALL be strict raster order regardless of engine completion order.

Reset
REQ-033 On areset high at an edge, the block SHALL reset as follows:
- all slots FREE; dptr = rptr = 0; coordinates (0,0);
- eng_start = 0, pix_valid = 0, frame_done = 0, busy = 0;
- eng_x = eng_y = 0, pix_iter = 0.
REQ-034 areset mid-frame SHALL abandon all in-flight pixels. eng_done pulses arriving after reset SHALL be ignored (slots not PENDING).
REQ-035 The first dispatch after reset release SHALL be (0,0) to engine 0.

Verification
Bench parameters for REQ-036 to REQ-040: X_SIZE=4, Y_SIZE=2, NUM_ENGINES=4.
REQ-036 Reset release, enable=1, engines respond in order with iter = 10+k, pix_ready=1.
- Required: eng_start 0001,0010,0100,1000 on consecutive cycles with (0,0),(1,0),(2,0),(3,0).
- Required: pix_iter 10,11,12,13; pix_sof on the first pixel only; pix_eol on the fourth.
REQ-037 Out-of-order completion: engine 2 done (iter 7), then engine 0 (iter 3), then engine 1 (iter 5).
- Required: no pix_valid until engine 0 is done, then pix_iter 3, 5, 7 in that order.
REQ-038 Backpressure: pix_ready=0 for 5 cycles with slot 0 HELD (iter 9).
- Required: pix_valid=1 and pix_iter=9 stable for all 5 cycles, and no dispatch to slot 0.
REQ-039 Full frame of 8 pixels accepted.
- Required: frame_done pulses once, 1 cycle after the eighth accept.
- Required: the next eng_start is to engine 0 with (0,0).
REQ-040 Combined reset and enable check.
- areset after 3 dispatches, then a stale eng_done[1]: required no pix_valid and busy=0.
- enable=0 mid-frame: no new eng_start, in-flight pixels retire.
- enable=1 again: dispatch resumes at the next coordinate.
